// File: rtl/flow_pkg.sv
// Shared constants and types for the round-robin channel arbiter.
// Imported by the arbiter top and its picker.
package flow_pkg;

    localparam int NCH  = 32;
    localparam int W    = 20;
    localparam int SELW = $clog2(NCH);

    typedef logic [W-1:0]    chan_word_t;
    typedef logic [SELW-1:0] chan_sel_t;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible channel after ptr.
// Double-width rotate followed by a lowest-bit priority search.
module rr_pick
    import flow_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] mask,
    input  chan_sel_t      ptr,
    output logic           found,
    output logic [NCH-1:0] onehot,
    output chan_sel_t      idx
);

    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic [SELW:0]    start;

    // start can reach NCH, which selects the upper copy unrotated
    always_comb begin
        start = {1'b0, ptr} + (SELW+1)'(1);
        dbl   = {req & mask, req & mask};
        rot   = '0;
        for (int i = 0; i < NCH; i++) begin
            rot[i] = dbl[start + (SELW+1)'(i)];
        end
    end

    // descending scan leaves the lowest rotated hit in idx
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                idx   = SELW'(start + (SELW+1)'(i));
            end
        end
        onehot = found ? (NCH'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_channel_arbiter.sv
// 32-channel round-robin arbiter with burst lock and a registered
// output slot on a valid/ready handshake.
module rr_channel_arbiter
    import flow_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req_valid,
    input  logic [NCH-1:0][W-1:0] req_data,
    input  logic [NCH-1:0]        req_lock,
    output logic [NCH-1:0]        req_ready,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    output logic [SELW-1:0]       out_sel,
    output logic [NCH-1:0]        grant_onehot,
    input  logic                  out_ready
);

    arb_state_t     state_q, state_d;
    chan_sel_t      lock_ch_q, lock_ch_d;
    chan_sel_t      ptr_q, ptr_d;
    logic           valid_q, valid_d;
    chan_word_t     data_q, data_d;
    chan_sel_t      sel_q, sel_d;
    logic [NCH-1:0] grant_q, grant_d;

    logic           load_en;
    logic           accept;
    logic [NCH-1:0] mask;
    logic           pick_found;
    logic [NCH-1:0] pick_onehot;
    chan_sel_t      pick_idx;

    rr_pick u_pick (
        .req    (req_valid),
        .mask   (mask),
        .ptr    (ptr_q),
        .found  (pick_found),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign load_en = !valid_q || out_ready;
    assign accept  = load_en && pick_found && !rst;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OPEN;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // next-state logic: the lock bit rides with each accepted beat
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        if (accept) begin
            if (req_lock[pick_idx]) begin
                state_d   = LOCKED;
                lock_ch_d = pick_idx;
            end else begin
                state_d   = OPEN;
            end
        end
    end

    // output logic: a lock narrows eligibility to the locked channel
    always_comb begin
        mask      = '1;
        req_ready = '0;
        if (state_q == LOCKED) begin
            mask = NCH'(1) << lock_ch_q;
        end
        if (accept) begin
            req_ready = pick_onehot;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        if (accept) begin
            ptr_d   = pick_idx;
            valid_d = 1'b1;
            data_d  = req_data[pick_idx];
            sel_d   = pick_idx;
            grant_d = pick_onehot;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // ptr resets to the last channel so channel 0 is searched first
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= chan_sel_t'(NCH - 1);
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_sel      = sel_q;
    assign grant_onehot = grant_q;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed bench for rr_channel_arbiter with hand-computed expectations.
// Inputs change 1ns after posedge; outputs are sampled 1-2ns after.
module tb_rr_channel_arbiter;
    import flow_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH-1:0]        req_valid;
    logic [NCH-1:0][W-1:0] req_data;
    logic [NCH-1:0]        req_lock;
    logic [NCH-1:0]        req_ready;
    logic                  out_valid;
    logic [W-1:0]          out_data;
    logic [SELW-1:0]       out_sel;
    logic [NCH-1:0]        grant_onehot;
    logic                  out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    rr_channel_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_lock     (req_lock),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sel      (out_sel),
        .grant_onehot (grant_onehot),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one accepted beat: comb ready now, registered slot after the edge
    task automatic beat(input string tag, input int ch,
                        input logic [W-1:0] d);
        logic [NCH-1:0] oh;
        oh = NCH'(1) << ch;
        #1;
        check({tag, ".rdy"}, 64'(req_ready), 64'(oh));
        tick();
        check({tag, ".vld"}, 64'(out_valid), 64'd1);
        check({tag, ".sel"}, 64'(out_sel), 64'(ch));
        check({tag, ".dat"}, 64'(out_data), 64'(d));
        check({tag, ".gnt"}, 64'(grant_onehot), 64'(oh));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 32'h0000_0005;
        req_data  = '0;
        req_lock  = '0;
        out_ready = 1'b1;
        req_data[0] = 20'h00AAA;
        req_data[2] = 20'h00BBB;
        tick();
        tick();
        #1;
        check("rst.rdy", 64'(req_ready), 64'd0);
        check("rst.vld", 64'(out_valid), 64'd0);
        check("rst.dat", 64'(out_data), 64'd0);
        check("rst.sel", 64'(out_sel), 64'd0);
        check("rst.gnt", 64'(grant_onehot), 64'd0);
        tick();
        rst = 1'b0;

        // alternating pair
        beat("alt0", 0, 20'h00AAA);
        beat("alt1", 2, 20'h00BBB);
        beat("alt2", 0, 20'h00AAA);
        beat("alt3", 2, 20'h00BBB);

        // wrap-around past channel 31
        req_valid    = 32'h8000_0000;
        req_data[31] = 20'h31F31;
        beat("wr_set", 31, 20'h31F31);
        req_valid = 32'h8000_0001;
        beat("wr_c0", 0, 20'h00AAA);
        beat("wr_c31", 31, 20'h31F31);

        // backpressure hold on ch7
        req_valid   = 32'h0000_0080;
        req_data[7] = 20'h12345;
        beat("bp_load", 7, 20'h12345);
        out_ready   = 1'b0;
        req_data[7] = 20'h54321;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rdy", 64'(req_ready), 64'd0);
            tick();
            check("bp_vld", 64'(out_valid), 64'd1);
            check("bp_dat", 64'(out_data), 64'h12345);
        end
        out_ready = 1'b1;
        beat("bp_rel", 7, 20'h54321);

        // burst lock on ch3 while ch4 waits
        req_valid   = 32'h0000_0018;
        req_data[3] = 20'h30001;
        req_data[4] = 20'h44444;
        req_lock    = 32'h0000_0008;
        beat("lk1", 3, 20'h30001);
        req_data[3] = 20'h30002;
        beat("lk2", 3, 20'h30002);
        req_data[3] = 20'h30003;
        req_lock    = '0;
        beat("lk3", 3, 20'h30003);
        req_valid   = 32'h0000_0010;
        beat("lk_c4", 4, 20'h44444);

        // locked on ch9: other channels idle, slot drains
        req_valid   = 32'h0000_0200;
        req_lock    = 32'h0000_0200;
        req_data[9] = 20'h99999;
        req_data[1] = 20'h11111;
        beat("rs_lock", 9, 20'h99999);
        req_valid = 32'h0000_0002;
        req_lock  = '0;
        #1;
        check("rs_idle.rdy", 64'(req_ready), 64'd0);
        tick();
        check("rs_drain.vld", 64'(out_valid), 64'd0);
        check("rs_drain.sel", 64'(out_sel), 64'd9);
        req_valid = 32'h0000_0200;
        req_lock  = 32'h0000_0200;
        beat("rs_relock", 9, 20'h99999);

        // reset while holding a locked word
        out_ready = 1'b0;
        rst       = 1'b1;
        req_valid = 32'h0000_0202;
        req_lock  = '0;
        #1;
        check("rs_rst.rdy", 64'(req_ready), 64'd0);
        tick();
        check("rs_rst.vld", 64'(out_valid), 64'd0);
        check("rs_rst.sel", 64'(out_sel), 64'd0);
        check("rs_rst.gnt", 64'(grant_onehot), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        beat("rs_first", 1, 20'h11111);
        beat("rs_second", 9, 20'h99999);

        // single requester, back-to-back
        req_valid = 32'h0000_1000;
        for (int k = 0; k < 10; k++) begin
            req_data[12] = 20'hC0000 + W'(k);
            beat("solo", 12, 20'hC0000 + W'(k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
